pattern_seq_monitor: RTL and testbench

Downstream consumer of the 4-bit step-pattern generator. Samples the generator's 4-bit output on a valid strobe and checks it against the fixed 7-step code sequence. Acquires and holds lock on the sequence, and flags and counts mismatches. Feeds lock/error status to the system controller.

---
 rtl/pattern_seq_pkg.sv | 12 +
 rtl/pattern_seq_monitor_sat_counter.sv | 17 +
 rtl/pattern_seq_monitor.sv | 93 +++++++++
 tb/tb_pattern_seq_monitor.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared code table, anchor and state encoding for the step-pattern generator and monitor.
package pattern_seq_pkg;
  localparam int SEQ_LEN = 7;
  localparam logic [3:0] ANCHOR_CODE = 4'b0001;
  // index 0 sits in the least significant nibble
  localparam logic [SEQ_LEN-1:0][3:0] SEQ_TABLE = {4'b0000, 4'b1101, 4'b1001, 4'b0111,
                                                   4'b0011, 4'b0001, 4'b0000};
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'(SEQ_LEN - 1)) ? 3'd0 : i + 3'd1;
  endfunction
endpackage

// File: rtl/pattern_seq_monitor_sat_counter.sv
// sat_counter: saturating up-counter with a clear that wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pattern_seq_monitor.sv
// pattern_seq_monitor: acquires lock on the 7-step code sequence, flywheels through it and counts mismatches.
module pattern_seq_monitor
  import pattern_seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 2,
  parameter int unsigned UNLOCK_ERRS = 3,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  input  logic             clear,
  output logic             locked,
  output logic [2:0]       step_idx,
  output logic             mismatch,
  output logic             seq_done,
  output logic [ERR_W-1:0] err_cnt
);
  state_e     state_q, state_d;
  logic [2:0] exp_q, exp_d, good_q, good_d, cerr_q, cerr_d;
  logic       mismatch_q, mismatch_d, seq_done_q, seq_done_d, err_inc, hit, anchor;
  assign hit    = in_code == SEQ_TABLE[exp_q];
  assign anchor = in_code == ANCHOR_CODE;
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    good_d     = good_q;
    cerr_d     = cerr_q;
    mismatch_d = 1'b0;
    seq_done_d = 1'b0;
    err_inc    = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: if (anchor) begin
          good_d  = 3'd1;
          exp_d   = 3'd2;
          state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
        end
        VERIFY: if (hit) begin
          good_d = good_q + 3'd1;
          exp_d  = next_idx(exp_q);
          if (good_d == 3'(LOCK_COUNT)) begin
            state_d = LOCKED;
            cerr_d  = 3'd0;
          end
        end else begin
          // a mismatching anchor restarts verification in place
          good_d  = anchor ? 3'd1 : 3'd0;
          exp_d   = anchor ? 3'd2 : 3'd0;
          state_d = anchor ? VERIFY : SEARCH;
        end
        LOCKED: begin
          exp_d      = next_idx(exp_q);
          seq_done_d = hit && exp_q == 3'd6;
          mismatch_d = !hit;
          err_inc    = !hit;
          cerr_d     = hit ? 3'd0 : cerr_q + 3'd1;
          if (!hit && cerr_d == 3'(UNLOCK_ERRS)) begin
            state_d = SEARCH;
            exp_d   = 3'd0;
            cerr_d  = 3'd0;
            good_d  = 3'd0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= SEARCH;
      exp_q      <= 3'd0;
      good_q     <= 3'd0;
      cerr_q     <= 3'd0;
      mismatch_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      good_q     <= good_d;
      cerr_q     <= cerr_d;
      mismatch_q <= mismatch_d;
      seq_done_q <= seq_done_d;
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst_n(rst_n), .inc_i(err_inc), .clr_i(clear), .cnt_o(err_cnt)
  );
  assign locked   = state_q == LOCKED;
  assign step_idx = exp_q;
  assign mismatch = mismatch_q;
  assign seq_done = seq_done_q;
endmodule

// File: tb/tb_pattern_seq_monitor.sv
// tb_pattern_seq_monitor: directed plus random stimulus against a behavioural model; a second instance uses ERR_W=2.
module tb_pattern_seq_monitor;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clear = 1'b0;
  logic [3:0] in_code = 4'd0;
  logic       locked, mismatch, seq_done, locked2, mismatch2, seq_done2;
  logic [2:0] step_idx, step_idx2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int n_chk = 0, n_fail = 0;
  int tbl[7] = '{0, 1, 3, 7, 9, 13, 0};
  int m_mode, m_exp, m_good, m_cerr, m_err8, m_err2;
  bit m_mis, m_done;

  always #5 clk = ~clk;

  pattern_seq_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .clear(clear),
    .locked(locked), .step_idx(step_idx), .mismatch(mismatch), .seq_done(seq_done), .err_cnt(err_cnt)
  );
  pattern_seq_monitor #(.ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .clear(clear),
    .locked(locked2), .step_idx(step_idx2), .mismatch(mismatch2), .seq_done(seq_done2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_good = 0; m_cerr = 0; m_err8 = 0; m_err2 = 0; m_mis = 0; m_done = 0;
  endtask

  // mode: 0 searching, 1 verifying, 2 locked
  task automatic model_step(input bit v, input int code, input bit clr);
    bit hit;
    m_mis = 0; m_done = 0;
    if (v) begin
      hit = code == tbl[m_exp];
      if (m_mode == 0) begin
        if (code == 1) begin m_good = 1; m_exp = 2; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (hit) begin
          m_good++; m_exp = (m_exp + 1) % 7;
          if (m_good >= 2) begin m_mode = 2; m_cerr = 0; end
        end else if (code == 1) begin m_good = 1; m_exp = 2; end
        else begin m_mode = 0; m_good = 0; m_exp = 0; end
      end else begin
        m_done = hit && m_exp == 6;
        m_exp = (m_exp + 1) % 7;
        if (hit) m_cerr = 0;
        else begin
          m_mis = 1; m_cerr++;
          if (m_cerr == 3) begin m_mode = 0; m_exp = 0; m_cerr = 0; m_good = 0; end
        end
      end
    end
    m_err8 = clr ? 0 : (m_mis && m_err8 < 255) ? m_err8 + 1 : m_err8;
    m_err2 = clr ? 0 : (m_mis && m_err2 < 3) ? m_err2 + 1 : m_err2;
  endtask

  task automatic compare_all();
    int exp_idx;
    exp_idx = (m_mode == 0) ? 0 : m_exp;
    chk("locked", 32'(locked), 32'(m_mode == 2));
    chk("step_idx", 32'(step_idx), 32'(exp_idx));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("seq_done", 32'(seq_done), 32'(m_done));
    chk("err_cnt", 32'(err_cnt), 32'(m_err8));
    chk("err_cnt2", 32'(err_cnt2), 32'(m_err2));
    chk("status2", {25'd0, locked2, step_idx2, mismatch2, seq_done2, 1'b0},
        {25'd0, 1'(m_mode == 2), 3'(exp_idx), 1'(m_mis), 1'(m_done), 1'b0});
  endtask

  // called at a falling edge: drive, clock, then compare at the next falling edge
  task automatic s(input bit v, input logic [3:0] code, input bit clr = 1'b0);
    in_valid = v; in_code = code; clear = clr;
    @(posedge clk);
    model_step(v, int'(code), clr);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int r;
    logic [3:0] c;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    s(1, 4'b0000); s(1, 4'b0001); s(1, 4'b0011);
    chk("lock_after_0011", 32'(locked), 32'd1);
    chk("lock_step3", 32'(step_idx), 32'd3);
    s(1, 4'b0111); s(1, 4'b1001); s(1, 4'b1101); s(1, 4'b0000);
    chk("seq_done_idx6", 32'(seq_done), 32'd1);
    s(1, 4'b0000); s(1, 4'b0001); s(1, 4'b0011);
    s(1, 4'b1111);
    chk("single_mismatch", 32'(err_cnt), 32'd1);
    s(1, 4'b1001);
    chk("flywheel_match", 32'(mismatch), 32'd0);
    s(1, 4'b1101); s(1, 4'b0000);
    s(1, 4'b1111); s(1, 4'b1111); s(1, 4'b1111);
    chk("unlock_after_3", 32'(locked), 32'd0);
    s(1, 4'b0001); s(1, 4'b0011);
    chk("relock", 32'(locked), 32'd1);
    s(1, 4'b1111); s(1, 4'b1111); s(1, 4'b1111);
    s(1, 4'b0001); s(1, 4'b0001);
    chk("reanchor_idx", 32'(step_idx), 32'd2);
    s(1, 4'b0011);
    chk("relock_verify", 32'(locked), 32'd1);
    chk("err2_saturated", 32'(err_cnt2), 32'd3);
    s(1, 4'b1111, 1'b1);
    chk("clear_priority", 32'(err_cnt), 32'd0);
    s(0, 4'b1001);
    s(1, 4'b1111);
    in_valid = 1'b1; in_code = 4'b1001;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {locked, step_idx, mismatch, seq_done, err_cnt, err_cnt2, locked2},
        17'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 9));
      c = (r < 6) ? 4'(tbl[m_exp]) : (r < 8) ? 4'b0001 : 4'($urandom);
      s($urandom_range(0, 4) != 0, c, $urandom_range(0, 19) == 0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
